axi_mst_read_ot: RTL

- Next-generation AXI4 read DMA master for the DDR bandwidth test path.
- Streams NBURST bursts of runtime-selectable length from DDR into an AXIS master port.
- Keeps up to MAX_OT read bursts outstanding, gated by FIFO space credits, so sustained bandwidth is not limited by read latency.
- Sits between the PS/DDR HP port and the AXIS consumer; reports completion, response errors, 4KB-boundary violations and a beat count to the register block.

---
 rtl/axi_mst_read_ot.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mst_read_ot.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axi_mst_read_ot
// AXI4 read DMA master for the DDR bandwidth test path. Streams NBURST bursts
// of (LEN+1) beats from DDR into an AXIS master port, keeping up to MAX_OT
// read bursts in flight. A burst is only requested once the read-data FIFO
// has room reserved for all of its beats, so rready never has to drop while
// data is owed to us.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   m_axi_ar*         AR channel (single ID 0, INCR, full-width beats)
//   m_axi_r*          R channel; rid is ignored, rready = FIFO not full
//   m_axis_*          AXIS stream out of the FIFO (first-word-fall-through)
//   START_REG         level input, 0->1 edge in IDLE starts a transfer
//   ADDR/NBURST/LEN   transfer configuration, latched on start
//   IDLE/DONE/RESP_ERR/BND_ERR/BEATS  status back to the register block
// -----------------------------------------------------------------------------
module axi_mst_read_ot #(
   parameter int ID_WIDTH   = 6,
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 8,
   parameter int FIFO_DEPTH = 64,
   parameter int MAX_OT     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [ID_WIDTH-1:0]     m_axi_arid,
   output logic [31:0]             m_axi_araddr,
   output logic [LEN_WIDTH-1:0]    m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic [1:0]              m_axi_arlock,
   output logic [3:0]              m_axi_arcache,
   output logic [2:0]              m_axi_arprot,
   output logic [3:0]              m_axi_arqos,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [ID_WIDTH-1:0]     m_axi_rid,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   output logic                    m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   input  logic                    START_REG,
   input  logic [31:0]             ADDR_REG,
   input  logic [31:0]             NBURST_REG,
   input  logic [LEN_WIDTH-1:0]    LEN_REG,
   output logic                    IDLE_REG,
   output logic                    DONE_REG,
   output logic                    RESP_ERR_REG,
   output logic                    BND_ERR_REG,
   output logic [31:0]             BEATS_REG
);

   localparam int BPB = DATA_WIDTH / 8;
   localparam int SZ  = $clog2(BPB);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int OW  = 5;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [OW-1:0] MAX_OT_C = OW'(MAX_OT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                  state;
   logic                    start_q;
   logic [31:0]             addr_q;
   logic [31:0]             nburst_q;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [31:0]             issued;
   logic [31:0]             completed;
   logic [31:0]             beats;
   logic [31:0]             pop_cnt;
   logic [31:0]             last_idx;
   logic [OW-1:0]           outstanding;
   logic [CW-1:0]           reserved;
   logic [CW-1:0]           count;
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic                    arvalid_q;
   logic                    done_q;
   logic                    resp_err_q;
   logic                    bnd_err_q;
   logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];

   logic                    start_rise;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    push;
   logic                    pop;
   logic                    ar_hs;
   logic                    rlast_hs;
   logic [CW-1:0]           burst_beats;
   logic [CW-1:0]           free;
   logic [31:0]             burst_bytes;
   logic                    cross_4k;
   logic                    can_issue;
   logic                    unused_rid;

   assign start_rise  = START_REG & ~start_q;
   assign fifo_full   = (count == DEPTH_C);
   assign fifo_empty  = (count == '0);
   assign push        = m_axi_rvalid & ~fifo_full;
   assign pop         = ~fifo_empty & m_axis_tready;
   assign ar_hs       = arvalid_q & m_axi_arready;
   assign rlast_hs    = push & m_axi_rlast;
   assign burst_beats = CW'(len_q) + CW'(1);
   // Space that is neither holding data nor promised to an issued burst.
   assign free        = DEPTH_C - count - reserved;
   assign burst_bytes = (32'(len_q) + 32'd1) << SZ;
   // A burst may end exactly on the 4KB line but not run past it.
   assign cross_4k    = (32'(addr_q[11:0]) + burst_bytes) > 32'd4096;
   assign can_issue   = (outstanding < MAX_OT_C) && (free >= burst_beats);
   assign unused_rid  = ^m_axi_rid;

   assign m_axi_arid    = '0;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = len_q;
   assign m_axi_arsize  = 3'(SZ);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = '0;
   assign m_axi_arcache = '0;
   assign m_axi_arprot  = '0;
   assign m_axi_arqos   = '0;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = ~fifo_full;
   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tdata  = mem[rd_ptr];
   assign m_axis_tstrb  = '1;
   // An aborted transfer never reaches its final beat, so no tlast then.
   assign m_axis_tlast  = ~fifo_empty & ~bnd_err_q & (pop_cnt == last_idx);
   assign IDLE_REG      = (state == S_IDLE);
   assign DONE_REG      = done_q;
   assign RESP_ERR_REG  = resp_err_q;
   assign BND_ERR_REG   = bnd_err_q;
   assign BEATS_REG     = beats;

   // FIFO storage carries data only and is not reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= m_axi_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         start_q     <= 1'b0;
         arvalid_q   <= 1'b0;
         done_q      <= 1'b0;
         resp_err_q  <= 1'b0;
         bnd_err_q   <= 1'b0;
         issued      <= '0;
         completed   <= '0;
         beats       <= '0;
         pop_cnt     <= '0;
         last_idx    <= '0;
         outstanding <= '0;
         reserved    <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         start_q <= START_REG;

         // FIFO and credit bookkeeping; AR and rlast in one cycle net out.
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count       <= count + CW'(push) - CW'(pop);
         reserved    <= reserved + (ar_hs ? burst_beats : CW'(0)) - CW'(push);
         outstanding <= outstanding + OW'(ar_hs) - OW'(rlast_hs);
         if (push) beats <= beats + 32'd1;
         if (push && (m_axi_rresp != 2'b00)) resp_err_q <= 1'b1;
         if (rlast_hs) completed <= completed + 32'd1;
         if (pop) pop_cnt <= pop_cnt + 32'd1;

         if (ar_hs) begin
            arvalid_q <= 1'b0;
            addr_q    <= addr_q + burst_bytes;
            issued    <= issued + 32'd1;
         end

         case (state)
            S_IDLE: begin
               if (start_rise) begin
                  addr_q     <= ADDR_REG;
                  nburst_q   <= NBURST_REG;
                  len_q      <= LEN_REG;
                  last_idx   <= NBURST_REG * (32'(LEN_REG) + 32'd1) - 32'd1;
                  resp_err_q <= 1'b0;
                  bnd_err_q  <= 1'b0;
                  issued     <= '0;
                  completed  <= '0;
                  beats      <= '0;
                  pop_cnt    <= '0;
                  if (NBURST_REG == '0) begin
                     done_q <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     done_q <= 1'b0;
                     state  <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               // A raised arvalid is left alone until its handshake.
               if (!arvalid_q) begin
                  if (issued == nburst_q) begin
                     state <= S_DRAIN;
                  end else if (cross_4k) begin
                     bnd_err_q <= 1'b1;
                     state     <= S_DRAIN;
                  end else if (can_issue) begin
                     arvalid_q <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if ((outstanding == '0) && (completed == issued) && fifo_empty) begin
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (!START_REG) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
